ssp_slave: RTL and testbench
============================

Name: ssp_slave

Overview:
- SPI mode-0 responder (target) for the CPU's SSP master port: it answers ssp_clk_o / ssp_en_o / ssp_mosi_o and returns ssp_miso_i.
- Lets on-chip or board-level loopback peripherals talk to the core over SPI, and gives the bench a self-checking SPI partner.
- All SPI pins are oversampled in the system clock domain; no logic is clocked by spi_sclk.
- Byte-wide (parameterisable) frames, MSB first, with a one-entry transmit buffer and a receive-valid pulse.

Parameters:
- DATA_W, 8: bits per frame.
- SYNC_STAGES, 2: synchroniser depth on spi_sclk, spi_cs_n and spi_mosi (minimum 2).
- TX_DEFAULT, 8'hFF: value shifted out when a frame starts with an empty transmit buffer. Width is DATA_W.

Ports:
- clk  in  1  system clock. spi_sclk must be at most clk/8.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from the master. Idles low (CPOL=0).
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  high while selected. The pad/top uses it for tri-state.
- tx_data  in  DATA_W  next byte to send.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  transmit buffer empty. Transfer occurs when tx_valid & tx_ready.
- rx_data  out  DATA_W  last complete received frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse when a frame starts with the buffer empty.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
  - Buffer empty, state IDLE, bit counter 0.
  - Synchroniser flops reset to idle levels: sclk=0, cs_n=1, mosi=0.
- Input conditioning:
  - Each SPI input passes through SYNC_STAGES flops.
  - Edges are detected against one further registered copy.
  - Every event is therefore seen SYNC_STAGES+1 clk after the pin transition.
- States: IDLE, LOAD, SHIFT.
  - IDLE → LOAD on a detected cs_n falling edge.
  - LOAD lasts one cycle:
    - If the buffer is full, shift register ← buffer, buffer marked empty.
    - If the buffer is empty, shift register ← TX_DEFAULT and tx_underrun pulses.
    - spi_miso ← MSB, bit counter ← 0, go to SHIFT.
  - SHIFT, sclk rising edge: rx shift register ← {rx[DATA_W-2:0], mosi_sync}; counter increments.
  - SHIFT, counter reaching DATA_W on that rising edge:
    - rx_data ← completed value and rx_valid=1 in the next cycle.
    - Counter ← 0.
    - A reload flag is set so the next falling edge performs the LOAD action instead of a shift.
  - SHIFT, sclk falling edge:
    - Normally the tx shift register shifts left and spi_miso ← new MSB.
    - If the reload flag is set, do the LOAD action (back-to-back frame while cs_n stays low) and clear the flag.
  - Any state: a detected cs_n rising edge aborts to IDLE.
    - A partial frame is discarded: no rx_valid, rx_data unchanged.
    - A byte already moved out of the buffer is lost; it is not restored.
- Output pins:
  - spi_miso_oe = registered (state != IDLE).
  - spi_miso holds its last value in IDLE but is undriven at the pad.
- Transmit buffer:
  - Writes are accepted in any state.
  - Accept and LOAD in the same cycle: the LOAD sees the old (empty) buffer → TX_DEFAULT sent, and the new byte is kept for the next frame.
  - tx_ready deasserts the cycle after acceptance and reasserts the cycle after LOAD consumes the byte.
- Receive side:
  - No backpressure. A new frame overwrites rx_data.
  - rx_valid is exactly one clk wide per completed frame.
- Simultaneous edges:
  - cs_n rising together with an sclk edge: the abort wins.
  - cs_n falling with sclk high is a protocol violation; the slave still enters LOAD and samples on the next rising edge.
- Overflow: the bit counter is log2(DATA_W)+1 bits and never wraps, because it is cleared at DATA_W.

Decomposition:
- Shared package ssp_pkg:
  - State enum ssp_state_t {IDLE, LOAD, SHIFT}.
  - Default DATA_W and TX_DEFAULT constants.
  - Shared with any future master-side SSP block.
- One natural sub-module: ssp_sync_edge. It is instantiated three times and provides:
  - SYNC_STAGES synchroniser plus edge detect.
  - Outputs: level, rise, fall.
  - Parameterised reset level.

Test Plan:
- Reset mid-frame: assert rst_n low during bit 4 → all outputs return to reset values immediately; the next full frame works normally.
- Preload 8'hA5 with tx_valid, then master sends 8'h3C with sclk=clk/8 → MISO bits 1,0,1,0,0,1,0,1. rx_data=8'h3C, one rx_valid pulse 3 clk after the 8th sclk rise, tx_ready high again after LOAD.
- Frame with no byte loaded, master sends 8'h00 → MISO returns 8'hFF, tx_underrun pulses once, rx_data=8'h00.
- Back-to-back: load 8'h11, start a frame, load 8'h22 during bit 3, hold cs_n low for 16 clocks → MISO 8'h11 then 8'h22, two rx_valid pulses, no underrun.
- Abort: cs_n rises after 5 bits of 8'hFF → no rx_valid, rx_data keeps its previous value, busy=0 three clk after cs_n rises, spi_miso_oe=0.
- Write collision: tx_valid with 8'h5A in the same cycle as LOAD on an empty buffer → this frame sends 8'hFF with an underrun pulse; the next frame sends 8'h5A.

Source files
------------

// File: rtl/ssp_pkg.sv
// ssp_pkg -- definitions shared by the SSP (SPI) blocks.
//   ssp_state_t    : frame state of the responder (IDLE, LOAD, SHIFT)
//   SSP_DATA_W     : default frame width in bits
//   SSP_TX_DEFAULT : default byte returned when nothing has been queued
// Kept separate so a master-side SSP block can reuse the same definitions.
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } ssp_state_t;

    localparam int         SSP_DATA_W     = 8;
    localparam logic [7:0] SSP_TX_DEFAULT = 8'hFF;

endpackage

// File: rtl/ssp_sync_edge.sv
// ssp_sync_edge -- brings one asynchronous pin into the clk domain and
// flags its edges.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_async    : raw pin
//   o_level    : synchronised level (STAGES flops deep)
//   o_rise     : one-cycle pulse, synchronised level went 0 -> 1
//   o_fall     : one-cycle pulse, synchronised level went 1 -> 0
// All flops reset to RESET_VAL, the pin's idle level, so no edge is
// reported merely because reset was released.
module ssp_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] w_sync_d;
    logic              r_prev;

    // Stage 0 takes the pin, every later stage takes its predecessor.
    assign w_sync_d[0] = i_async;
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
            assign w_sync_d[gi] = r_sync[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= w_sync_d;
            r_prev <= r_sync[STAGES-1];
        end
    end

    // Edges compare the synchronised level with one more registered copy.
    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/ssp_slave.sv
// ssp_slave -- SPI mode-0 responder, fully oversampled in the clk domain.
//   clk, rst_n          : system clock (>= 8x spi_sclk), async active-low reset
//   spi_sclk/cs_n/mosi  : SPI pins from the master
//   spi_miso            : slave-out data, MSB first
//   spi_miso_oe         : high while selected (pad tri-state control)
//   tx_data/valid/ready : one-entry transmit buffer, accepted on valid & ready
//   rx_data, rx_valid   : last complete frame, one-cycle valid pulse
//   tx_underrun         : pulse when a frame starts with the buffer empty
//   busy                : frame state is not IDLE
module ssp_slave
    import ssp_pkg::*;
#(
    parameter int                DATA_W      = SSP_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_DEFAULT  = DATA_W'(SSP_TX_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    // One extra bit so the counter can hold DATA_W itself before clearing.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    // Conditioned pins
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level,   w_cs_rise,   w_cs_fall;
    logic w_mosi_level, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    ssp_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(spi_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    ssp_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    ssp_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(spi_mosi),
        .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Only edges of sclk/cs_n and the level of mosi matter here.
    assign w_unused = ^{w_sclk_level, w_cs_level, w_mosi_rise, w_mosi_fall};

    // Registers
    ssp_state_t          r_state, w_state_next;
    logic [DATA_W-1:0]   r_tx_buf;
    logic                r_buf_full;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_reload;
    logic                r_miso;
    logic                r_miso_oe;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_tx_underrun;

    // FSM decode outputs
    logic w_do_load, w_do_shift, w_do_sample, w_abort;

    logic              w_tx_accept;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_rx_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_frame_done;

    assign w_tx_accept  = tx_valid & ~r_buf_full;
    // LOAD looks at the buffer as it was before any same-cycle write.
    assign w_load_val   = r_buf_full ? r_tx_buf : TX_DEFAULT;
    assign w_rx_next    = (r_rx_shift << 1) | DATA_W'(w_mosi_level);
    assign w_cnt_inc    = r_bit_cnt + CNT_W'(1);
    assign w_frame_done = (w_cnt_inc == CNT_W'(DATA_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_do_load    = 1'b0;
        w_do_shift   = 1'b0;
        w_do_sample  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_do_load    = 1'b1;
                w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    w_do_sample = 1'b1;
                end else if (w_sclk_fall) begin
                    // After a completed frame the falling edge starts the
                    // next frame instead of shifting out a stale bit.
                    if (r_reload) begin
                        w_do_load = 1'b1;
                    end else begin
                        w_do_shift = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        // Deselect overrides anything an sclk edge would have done.
        if (w_cs_rise) begin
            w_abort      = 1'b1;
            w_state_next = IDLE;
            w_do_load    = 1'b0;
            w_do_shift   = 1'b0;
            w_do_sample  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_buf      <= '0;
            r_buf_full    <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_reload      <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_miso_oe     <= (w_state_next != IDLE);
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (w_do_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (w_tx_accept) begin
                r_tx_buf   <= tx_data;
                r_buf_full <= 1'b1;
            end

            if (w_do_load) begin
                r_tx_shift    <= w_load_val;
                r_miso        <= w_load_val[DATA_W-1];
                r_bit_cnt     <= '0;
                r_reload      <= 1'b0;
                r_tx_underrun <= ~r_buf_full;
            end

            if (w_do_shift) begin
                r_tx_shift <= r_tx_shift << 1;
                r_miso     <= r_tx_shift[DATA_W-2];
            end

            if (w_do_sample) begin
                r_rx_shift <= w_rx_next;
                if (w_frame_done) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_reload   <= 1'b1;
                end else begin
                    r_bit_cnt <= w_cnt_inc;
                end
            end

            if (w_abort) begin
                r_bit_cnt <= '0;
                r_reload  <= 1'b0;
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ssp_slave.sv
// tb_ssp_slave -- directed bench for ssp_slave with a frame-level model.
module tb_ssp_slave;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    ssp_slave dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rxv_cnt = 0;
    int rxv_cyc = 0;
    int urun_cnt = 0;
    int rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pins as the responder sees them: the bench's own pin values seen
    // through a three-clock conditioning delay.
    logic p0_sclk = 0, p1_sclk = 0, p2_sclk = 0;
    logic p0_cs = 1,   p1_cs = 1,   p2_cs = 1;
    logic p0_mosi = 0, p1_mosi = 0;
    bit         m_active = 0, m_load_pend = 0, m_reload = 0;
    int         m_bits = 0;
    logic [7:0] m_acc = 0;
    logic [7:0] m_buf_q[$];
    logic [7:0] exp_tx_q[$];
    logic       e_rx_valid = 0, e_underrun = 0, e_busy = 0, e_tx_ready = 1;
    logic [7:0] e_rx_data = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                p0_sclk = 0; p1_sclk = 0; p2_sclk = 0;
                p0_cs = 1;   p1_cs = 1;   p2_cs = 1;
                p0_mosi = 0; p1_mosi = 0;
                m_active = 0; m_load_pend = 0; m_reload = 0; m_bits = 0; m_acc = 0;
                m_buf_q.delete(); exp_tx_q.delete();
                e_rx_valid = 0; e_underrun = 0; e_busy = 0; e_tx_ready = 1; e_rx_data = 0;
            end else begin
                bit s_rise, s_fall, c_rise, c_fall, accept, load_now;
                s_rise = p1_sclk && !p2_sclk;
                s_fall = !p1_sclk && p2_sclk;
                c_rise = p1_cs && !p2_cs;
                c_fall = !p1_cs && p2_cs;
                accept = tx_valid && (m_buf_q.size() == 0);
                load_now = 0;
                e_rx_valid = 0;
                e_underrun = 0;
                if (c_rise) begin
                    m_active = 0; m_load_pend = 0; m_reload = 0; m_bits = 0;
                end else if (m_load_pend) begin
                    m_load_pend = 0; load_now = 1;
                end else if (!m_active) begin
                    if (c_fall) begin m_active = 1; m_load_pend = 1; end
                end else if (s_rise) begin
                    m_acc = {m_acc[6:0], p1_mosi};
                    m_bits++;
                    if (m_bits == 8) begin
                        e_rx_data = m_acc; e_rx_valid = 1; m_bits = 0; m_reload = 1;
                    end
                end else if (s_fall && m_reload) begin
                    m_reload = 0; load_now = 1;
                end
                if (load_now) begin
                    m_bits = 0;
                    if (m_buf_q.size() > 0) exp_tx_q.push_back(m_buf_q.pop_front());
                    else begin exp_tx_q.push_back(8'hFF); e_underrun = 1; end
                end
                if (accept) m_buf_q.push_back(tx_data);
                e_busy = m_active;
                e_tx_ready = (m_buf_q.size() == 0);
                p2_sclk = p1_sclk; p1_sclk = p0_sclk; p0_sclk = spi_sclk;
                p2_cs   = p1_cs;   p1_cs   = p0_cs;   p0_cs   = spi_cs_n;
                p1_mosi = p0_mosi; p0_mosi = spi_mosi;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("rx_valid",    rx_valid,    e_rx_valid);
            check("tx_underrun", tx_underrun, e_underrun);
            check("busy",        busy,        e_busy);
            check("miso_oe",     spi_miso_oe, e_busy);
            check("tx_ready",    tx_ready,    e_tx_ready);
            check("rx_data",     rx_data,     e_rx_data);
            if (rx_valid === 1'b1) begin rxv_cnt++; rxv_cyc = cyc; end
            if (tx_underrun === 1'b1) urun_cnt++;
        end
    end

    // ---------------- SPI master / host tasks (called at a negedge) ----------------
    task automatic host_write(input logic [7:0] b);
        tx_valid = 1'b1; tx_data = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_start();
        spi_cs_n = 1'b0; spi_sclk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b0; spi_mosi = mo[7-i];
            repeat (4) @(negedge clk);
            got = {got[6:0], spi_miso};
            rise_cyc = cyc;
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        if (nbits == 8) begin
            if (exp_tx_q.size() == 0) check("miso_frame_started", 32'(exp_tx_q.size()), 1);
            else check("miso_byte", got, exp_tx_q.pop_front());
        end
    endtask

    // sclk returns low together with cs_n rising, so the deselect wins.
    task automatic spi_end();
        spi_sclk = 1'b0; spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        exp_tx_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] g0, g1;
        int r0, u0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_miso", spi_miso, 0);

        // Preloaded A5 returned while 3C is received.
        host_write(8'hA5);
        @(negedge clk);
        check("t1_tx_ready_low", tx_ready, 0);
        r0 = rxv_cnt;
        spi_start();
        check("t1_tx_ready_after_load", tx_ready, 1);
        spi_byte(8'h3C, 8, g0);
        check("t1_miso_lit", g0, 8'hA5);
        check("t1_rx_data_lit", rx_data, 8'h3C);
        check("t1_rxv_count", rxv_cnt - r0, 1);
        check("t1_rxv_latency", rxv_cyc - rise_cyc, 3);
        spi_end();

        // Empty buffer: default byte and one underrun.
        u0 = urun_cnt;
        spi_start();
        spi_byte(8'h00, 8, g0);
        spi_end();
        check("t2_miso_lit", g0, 8'hFF);
        check("t2_underrun_count", urun_cnt - u0, 1);
        check("t2_rx_data_lit", rx_data, 8'h00);

        // Back-to-back frames, second byte written during bit 3.
        host_write(8'h11);
        r0 = rxv_cnt; u0 = urun_cnt;
        fork
            begin
                spi_start();
                spi_byte(8'hC3, 8, g0);
                spi_byte(8'h96, 8, g1);
                spi_end();
            end
            begin
                repeat (8 + 2*8 + 3) @(negedge clk);
                host_write(8'h22);
            end
        join
        check("t3_miso0_lit", g0, 8'h11);
        check("t3_miso1_lit", g1, 8'h22);
        check("t3_rxv_count", rxv_cnt - r0, 2);
        check("t3_underrun_count", urun_cnt - u0, 0);
        check("t3_rx_data_lit", rx_data, 8'h96);

        // Abort after 5 bits of FF.
        r0 = rxv_cnt;
        spi_start();
        spi_byte(8'hFF, 5, g0);
        spi_sclk = 1'b0; spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_busy_before", busy, 1);
        @(negedge clk);
        check("t4_busy_after3", busy, 0);
        check("t4_oe_after3", spi_miso_oe, 0);
        repeat (5) @(negedge clk);
        exp_tx_q.delete();
        check("t4_no_rxv", rxv_cnt - r0, 0);
        check("t4_rx_data_kept", rx_data, 8'h96);

        // Write in the same cycle as LOAD on an empty buffer.
        u0 = urun_cnt;
        fork
            begin
                spi_start();
                spi_byte(8'h81, 8, g0);
                spi_end();
            end
            begin
                repeat (3) @(negedge clk);
                host_write(8'h5A);
            end
        join
        check("t5_miso_lit", g0, 8'hFF);
        check("t5_underrun_count", urun_cnt - u0, 1);
        u0 = urun_cnt;
        spi_start();
        spi_byte(8'h7E, 8, g0);
        spi_end();
        check("t5_next_miso_lit", g0, 8'h5A);
        check("t5_next_no_underrun", urun_cnt - u0, 0);
        check("t5_rx_data_lit", rx_data, 8'h7E);

        // Reset during bit 4, then a normal frame.
        host_write(8'h33);
        spi_start();
        spi_byte(8'hAA, 4, g0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_oe", spi_miso_oe, 0);
        check("t6_rst_tx_ready", tx_ready, 1);
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_rst_miso", spi_miso, 0);
        @(negedge clk);
        spi_sclk = 1'b0; spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        host_write(8'hC6);
        spi_start();
        spi_byte(8'h5A, 8, g0);
        spi_end();
        check("t6_miso_lit", g0, 8'hC6);
        check("t6_rx_data_lit", rx_data, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
